neo_strand_ctrl: RTL and testbench
==================================

NEO_STRAND_CTRL -- requirements
Module: neo_strand_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 5, number of pixels on the strand (1..256).
REQ-002 Parameter NUM_COLORS, default 3, colour channels per pixel: 3 = GRB, 4 = GRBW.
REQ-003 Parameter T0H, default 18, clock cycles neo_data is high for a 0 bit.
REQ-004 Parameter T1H, default 35, clock cycles neo_data is high for a 1 bit.
REQ-005 Parameter TBIT, default 63, clock cycles per bit period.
REQ-006 Parameter TLATCH, default 2500, clock cycles of low line after a frame.
REQ-007 clock  input  1  single system clock, 50 MHz nominal.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 pixel_index  input  $clog2(NUM_PIXELS) (minimum 1)  pixel to write.
REQ-010 color_index  input  2  channel to write: 0 = G, 1 = R, 2 = B, 3 = W.
REQ-011 color_level  input  8  intensity value to write.
REQ-012 load_color  input  1  write strobe, one cycle.
REQ-013 send_it  input  1  start-frame strobe, one cycle.
REQ-014 neo_data  output  1  serial line to the strand.
REQ-015 ready_to_load  output  1  high when load_color is accepted.
REQ-016 ready_to_send  output  1  high when send_it is accepted.

Function
REQ-017 The block SHALL hold a NUM_PIXELS x NUM_COLORS x 8-bit colour store.
REQ-018 load_color with ready_to_load high SHALL write color_level to [pixel_index][color_index] at the clock edge.
REQ-019 A write with pixel_index >= NUM_PIXELS or color_index >= NUM_COLORS SHALL be ignored.
REQ-020 The FSM SHALL have the states IDLE, SEND and LATCH.
REQ-021 IDLE: ready_to_load = ready_to_send = 1 and neo_data = 0.
REQ-022 SEND and LATCH: both ready outputs = 0.
REQ-023 load_color and send_it SHALL be ignored while the FSM is not in IDLE.
REQ-024 send_it in IDLE at edge N SHALL move the FSM to SEND, with neo_data high from cycle N+1.
REQ-025 Transmission order SHALL be pixel 0 to NUM_PIXELS-1; within a pixel, G, R, B, then W (W only if NUM_COLORS = 4); within a channel, MSB first.
REQ-026 Each bit SHALL last exactly TBIT cycles, high for T1H (bit = 1) or T0H (bit = 0), then low.
REQ-027 After the last bit the FSM SHALL enter LATCH and hold neo_data low for exactly TLATCH cycles, then return to IDLE.
REQ-028 A frame SHALL occupy NUM_PIXELS*NUM_COLORS*8*TBIT + TLATCH cycles from the first high cycle until ready_to_send rises.
REQ-029 When load_color and send_it are both asserted in IDLE in the same cycle, the write SHALL complete and the frame SHALL transmit the new value.
REQ-030 The transmitted frame SHALL be a function of the stored contents only; the colour store SHALL be unchanged by sending.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to neo_data.

Reset
REQ-032 While reset = 0 at a clock edge: FSM -> IDLE, all counters -> 0, neo_data -> 0, colour store -> all zeros.
REQ-033 Reset asserted during SEND or LATCH SHALL abort the frame on the next edge, with neo_data low from that edge.
REQ-034 ready_to_load and ready_to_send SHALL read 0 while reset is asserted and 1 on the first cycle after release.

Configuration
REQ-035 NEO_BRIGHTNESS_EN defined: add input brightness [7:0] (master scale), and transmit (level*(brightness+1))>>8 per channel, computed at byte fetch.
REQ-036 NEO_BRIGHTNESS_EN undefined: no brightness port, and stored levels are transmitted unmodified.

Structure
REQ-037 Package neo_pkg SHALL hold the colour_t enum (G, R, B, W), the default timing constants and the FSM state enum.
REQ-038 Sub-module neo_bit_timer SHALL take a bit value and a start strobe, drive the high/low waveform, and pulse done after TBIT cycles.

Verification
REQ-039 Default parameters, load pixel 0 G = 8'hFF and all others 0, then send_it: first 8 bits are 35-high/28-low and the remaining 112 bits are 18-high/45-low; ready_to_send rises 120*63 + 2500 = 10060 cycles after the first high cycle.
REQ-040 NUM_COLORS = 4, NUM_PIXELS = 2, load pixel 1 W = 8'h81: bits 56 and 63 are 1s and all others are 0s.
REQ-041 load_color with pixel_index = 7 (NUM_PIXELS = 5) followed by send: all 120 bits transmit as 0.
REQ-042 send_it and load_color pulsed mid-SEND: no store change, frame length unchanged, no restart.
REQ-043 reset = 0 at cycle 500 of a frame: neo_data = 0 the next cycle; after release, ready_to_send = 1 and a new send transmits all zeros.
REQ-044 NEO_BRIGHTNESS_EN defined, brightness = 8'h7F, level = 8'hFF: transmitted byte is 8'h7F.

Source files
------------

// File: rtl/neo_strand_ctrl_pkg.sv
// Shared types and default timing for the NeoPixel strand controller.
package neo_pkg;

   typedef enum logic [1:0] {G = 2'd0, R = 2'd1, B = 2'd2, W = 2'd3} colour_t;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_LATCH = 2'd2} neo_state_t;

   localparam int DEF_NUM_PIXELS = 5;
   localparam int DEF_NUM_COLORS = 3;
   localparam int DEF_T0H        = 18;
   localparam int DEF_T1H        = 35;
   localparam int DEF_TBIT       = 63;
   localparam int DEF_TLATCH     = 2500;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/neo_strand_ctrl_if.sv
// Load/send handshake and serial line of the strand controller.
// NEO_BRIGHTNESS_EN adds the master brightness input.
interface neo_strand_ctrl_if
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS = DEF_NUM_PIXELS
) ();
   localparam int PW = idx_width(NUM_PIXELS);

   logic [PW-1:0] pixel_index;
   logic [1:0]    color_index;
   logic [7:0]    color_level;
   logic          load_color;
   logic          send_it;
`ifdef NEO_BRIGHTNESS_EN
   logic [7:0]    brightness;
`endif
   logic          neo_data;
   logic          ready_to_load;
   logic          ready_to_send;

`ifdef NEO_BRIGHTNESS_EN
   modport master (output pixel_index, color_index, color_level, load_color, send_it, brightness,
                   input  neo_data, ready_to_load, ready_to_send);
   modport slave  (input  pixel_index, color_index, color_level, load_color, send_it, brightness,
                   output neo_data, ready_to_load, ready_to_send);
`else
   modport master (output pixel_index, color_index, color_level, load_color, send_it,
                   input  neo_data, ready_to_load, ready_to_send);
   modport slave  (input  pixel_index, color_index, color_level, load_color, send_it,
                   output neo_data, ready_to_load, ready_to_send);
`endif

endinterface

// File: rtl/neo_bit_timer.sv
// One bit period: line high for T1H/T0H cycles from the cycle after start, low for the rest;
// done is high in the last cycle of the period so a new start can follow back-to-back.
module neo_bit_timer
   import neo_pkg::*;
#(
   parameter int T0H  = DEF_T0H,
   parameter int T1H  = DEF_T1H,
   parameter int TBIT = DEF_TBIT
) (
   input  logic clock,
   input  logic reset,
   input  logic start_i,
   input  logic bit_i,
   output logic line_o,
   output logic done_o
);
   localparam int TW = idx_width(TBIT);

   logic [TW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          one_q, one_d;
   logic          line_q, line_d;
   int            th;

   assign done_o = busy_q && (cnt_q == TW'(TBIT - 1));
   assign line_o = line_q;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      one_d  = one_q;
      line_d = line_q;
      th     = one_q ? T1H : T0H;
      if (start_i) begin
         cnt_d  = '0;
         busy_d = 1'b1;
         one_d  = bit_i;
         line_d = 1'b1;
      end else if (busy_q) begin
         if (done_o) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            line_d = 1'b0;
         end else begin
            cnt_d  = cnt_q + TW'(1);
            line_d = (int'(cnt_q) + 1) < th;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         one_q  <= 1'b0;
         line_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         one_q  <= one_d;
         line_q <= line_d;
      end
   end

endmodule

// File: rtl/neo_strand_ctrl.sv
// NeoPixel strand driver: colour store, IDLE/SEND/LATCH frame FSM and bit serialiser.
// NEO_BRIGHTNESS_EN scales each byte by (brightness+1)/256 as it is fetched for transmission.
module neo_strand_ctrl
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS = DEF_NUM_PIXELS,
   parameter int NUM_COLORS = DEF_NUM_COLORS,
   parameter int T0H        = DEF_T0H,
   parameter int T1H        = DEF_T1H,
   parameter int TBIT       = DEF_TBIT,
   parameter int TLATCH     = DEF_TLATCH
) (
   input logic              clock,
   input logic              reset,
   neo_strand_ctrl_if.slave bus
);
   localparam int PW = idx_width(NUM_PIXELS);
   localparam int LW = idx_width(TLATCH);

   localparam logic [1:0] IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] SEND  = 2'(ST_SEND);
   localparam logic [1:0] LATCH = 2'(ST_LATCH);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pix_q, pix_d, nxt_pix, fetch_pix;
   colour_t       ch_q, ch_d, nxt_ch, fetch_ch;
   logic [2:0]    bitn_q, bitn_d;
   logic [7:0]    sh_q, sh_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          rdy_q, rdy_d;
   logic [7:0]    raw_byte, fetch_byte;
   logic          wr_en, start, tx_bit, bit_done, last_pix, last_ch, line;
   logic [7:0]    mem_q [NUM_PIXELS][NUM_COLORS];

   assign wr_en = (state_q == IDLE) && bus.load_color
                  && ({1'b0, bus.pixel_index} < (PW + 1)'(NUM_PIXELS))
                  && ({1'b0, bus.color_index} < 3'(NUM_COLORS));

   always_ff @(posedge clock) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
         for (int c = 0; c < NUM_COLORS; c++) begin
            if (!reset)
               mem_q[p][c] <= '0;
            else if (wr_en && int'(bus.pixel_index) == p && int'(bus.color_index) == c)
               mem_q[p][c] <= bus.color_level;
         end
      end
   end

   assign last_pix = (int'(pix_q) == NUM_PIXELS - 1);
   assign last_ch  = (int'(ch_q) == NUM_COLORS - 1);

   always_comb begin
      nxt_pix = pix_q;
      nxt_ch  = colour_t'(ch_q + 2'd1);
      if (last_ch) begin
         nxt_ch  = G;
         nxt_pix = pix_q + PW'(1);
      end
   end

   assign fetch_pix = (state_q == SEND) ? nxt_pix : '0;
   assign fetch_ch  = (state_q == SEND) ? nxt_ch : G;

   // Forward a same-cycle write so load_color + send_it transmits the new value.
   always_comb begin
      raw_byte = '0;
      for (int p = 0; p < NUM_PIXELS; p++)
         for (int c = 0; c < NUM_COLORS; c++)
            if (int'(fetch_pix) == p && int'(fetch_ch) == c)
               raw_byte = mem_q[p][c];
      if (wr_en && bus.pixel_index == fetch_pix && bus.color_index == fetch_ch)
         raw_byte = bus.color_level;
   end

`ifdef NEO_BRIGHTNESS_EN
   assign fetch_byte = 8'((16'(raw_byte) * (16'(bus.brightness) + 16'd1)) >> 8);
`else
   assign fetch_byte = raw_byte;
`endif

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      ch_d    = ch_q;
      bitn_d  = bitn_q;
      sh_d    = sh_q;
      lat_d   = lat_q;
      start   = 1'b0;
      tx_bit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.send_it) begin
               state_d = SEND;
               pix_d   = '0;
               ch_d    = G;
               start   = 1'b1;
               tx_bit  = fetch_byte[7];
               sh_d    = {fetch_byte[6:0], 1'b0};
               bitn_d  = '0;
            end
         end
         SEND: begin
            if (bit_done) begin
               if (bitn_q != 3'd7) begin
                  start  = 1'b1;
                  tx_bit = sh_q[7];
                  sh_d   = {sh_q[6:0], 1'b0};
                  bitn_d = bitn_q + 3'd1;
               end else if (last_pix && last_ch) begin
                  state_d = LATCH;
                  lat_d   = '0;
               end else begin
                  pix_d  = nxt_pix;
                  ch_d   = nxt_ch;
                  start  = 1'b1;
                  tx_bit = fetch_byte[7];
                  sh_d   = {fetch_byte[6:0], 1'b0};
                  bitn_d = '0;
               end
            end
         end
         LATCH: begin
            if (lat_q == LW'(TLATCH - 1))
               state_d = IDLE;
            else
               lat_d = lat_q + LW'(1);
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         pix_q   <= '0;
         ch_q    <= G;
         bitn_q  <= '0;
         sh_q    <= '0;
         lat_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         ch_q    <= ch_d;
         bitn_q  <= bitn_d;
         sh_q    <= sh_d;
         lat_q   <= lat_d;
         rdy_q   <= rdy_d;
      end
   end

   neo_bit_timer #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_bit_timer (
      .clock   (clock),
      .reset   (reset),
      .start_i (start),
      .bit_i   (tx_bit),
      .line_o  (line),
      .done_o  (bit_done)
   );

   assign bus.neo_data      = line;
   assign bus.ready_to_load = rdy_q;
   assign bus.ready_to_send = rdy_q;

endmodule

// File: tb/tb_neo_strand_ctrl.sv
// Bench for neo_strand_ctrl: random loads checked against a colour-store model and an ideal line waveform.
module tb_neo_strand_ctrl;
   localparam int NP = 5, NC = 3, NPB = 2, NCB = 4;
   localparam int T0H = 18, T1H = 35, TBIT = 63, TLATCH = 2500;
   localparam int PWA = (NP > 1) ? $clog2(NP) : 1;
   localparam int PWB = (NPB > 1) ? $clog2(NPB) : 1;

   typedef bit         bitq_t[$];
   typedef logic [7:0] byteq_t[$];

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #10 clock = ~clock;

   neo_strand_ctrl_if #(.NUM_PIXELS(NP))  bus_a ();
   neo_strand_ctrl_if #(.NUM_PIXELS(NPB)) bus_b ();

   neo_strand_ctrl #(.NUM_PIXELS(NP), .NUM_COLORS(NC), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH))
      dut_a (.clock(clock), .reset(reset), .bus(bus_a));
   neo_strand_ctrl #(.NUM_PIXELS(NPB), .NUM_COLORS(NCB), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH))
      dut_b (.clock(clock), .reset(reset), .bus(bus_b));

   logic [7:0] mdl_a [NP][NC];
   logic [7:0] mdl_b [NPB][NCB];
   logic [7:0] bright = 8'h7F;
   int n_chk = 0, n_pass = 0;

`ifdef NEO_BRIGHTNESS_EN
   assign bus_a.brightness = bright;
   assign bus_b.brightness = bright;
`endif

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [7:0] tx(input logic [7:0] v);
`ifdef NEO_BRIGHTNESS_EN
      int unsigned s = (int'(v) * (int'(bright) + 1)) / 256;
      return s[7:0];
`else
      return v;
`endif
   endfunction

   task automatic clear_models();
      foreach (mdl_a[p, c]) mdl_a[p][c] = 8'h00;
      foreach (mdl_b[p, c]) mdl_b[p][c] = 8'h00;
   endtask

   task automatic drive_a(input int p, input int c, input logic [7:0] v, input bit ld, input bit snd);
      bus_a.pixel_index = PWA'(p);
      bus_a.color_index = 2'(c);
      bus_a.color_level = v;
      bus_a.load_color  = ld;
      bus_a.send_it     = snd;
      if (ld && p < NP && c < NC) mdl_a[p][c] = v;
      @(negedge clock);
      bus_a.load_color = 1'b0;
      bus_a.send_it    = 1'b0;
   endtask

   task automatic drive_b(input int p, input int c, input logic [7:0] v, input bit ld, input bit snd);
      bus_b.pixel_index = PWB'(p);
      bus_b.color_index = 2'(c);
      bus_b.color_level = v;
      bus_b.load_color  = ld;
      bus_b.send_it     = snd;
      if (ld && p < NPB && c < NCB) mdl_b[p][c] = v;
      @(negedge clock);
      bus_b.load_color = 1'b0;
      bus_b.send_it    = 1'b0;
   endtask

   // Records the line from the first cycle after send_it until ready_to_send returns.
   task automatic capture_a(input bit poke, output bitq_t wave);
      int limit = NP * NC * 8 * TBIT + TLATCH + 200;
      wave = {};
      for (int i = 0; i < limit; i++) begin
         if (bus_a.ready_to_send) break;
         if (i == 100) check_eq("busy_ready_a", {bus_a.ready_to_load, bus_a.ready_to_send}, 0);
         wave.push_back(bus_a.neo_data);
         if (poke && i == 300) begin
            bus_a.pixel_index = '0;
            bus_a.color_index = 2'd0;
            bus_a.color_level = ~mdl_a[0][0];
            bus_a.load_color  = 1'b1;
            bus_a.send_it     = 1'b1;
         end
         if (poke && i == 301) begin
            bus_a.load_color = 1'b0;
            bus_a.send_it    = 1'b0;
         end
         @(negedge clock);
      end
   endtask

   task automatic capture_b(output bitq_t wave);
      int limit = NPB * NCB * 8 * TBIT + TLATCH + 200;
      wave = {};
      for (int i = 0; i < limit; i++) begin
         if (bus_b.ready_to_send) break;
         wave.push_back(bus_b.neo_data);
         @(negedge clock);
      end
   endtask

   task automatic analyse(input string nm, input bitq_t wave, input byteq_t exp_b);
      int nbits = exp_b.size() * 8;
      int errs  = 0;
      check_eq({nm, "_len"}, wave.size(), nbits * TBIT + TLATCH);
      for (int k = 0; k < exp_b.size(); k++) begin
         logic [7:0] got = '0;
         for (int b = 0; b < 8; b++) begin
            int hi = 0;
            bit e_bit = exp_b[k][7 - b];
            for (int j = 0; j < TBIT; j++) begin
               int idx = (k * 8 + b) * TBIT + j;
               bit s = (idx < wave.size()) ? wave[idx] : 1'b0;
               bit e = (j < (e_bit ? T1H : T0H));
               hi += int'(s);
               if (s != e) errs++;
            end
            got = {got[6:0], (hi > (T0H + T1H) / 2)};
         end
         check_eq($sformatf("%s_byte%0d", nm, k), got, exp_b[k]);
      end
      for (int i = nbits * TBIT; i < wave.size(); i++)
         if (wave[i]) errs++;
      check_eq({nm, "_wave"}, errs, 0);
   endtask

   task automatic frame_a(input string nm, input bit poke);
      bitq_t  w;
      byteq_t e = {};
      capture_a(poke, w);
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < NC; c++) e.push_back(tx(mdl_a[p][c]));
      analyse(nm, w, e);
   endtask

   initial begin
      bitq_t  wb;
      byteq_t eb;
      bus_a.pixel_index = '0; bus_a.color_index = '0; bus_a.color_level = '0;
      bus_a.load_color  = 1'b0; bus_a.send_it = 1'b0;
      bus_b.pixel_index = '0; bus_b.color_index = '0; bus_b.color_level = '0;
      bus_b.load_color  = 1'b0; bus_b.send_it = 1'b0;
      clear_models();

      repeat (3) @(negedge clock);
      check_eq("rst_ready_a", {bus_a.ready_to_load, bus_a.ready_to_send}, 0);
      check_eq("rst_data_a", bus_a.neo_data, 0);
      check_eq("rst_ready_b", {bus_b.ready_to_load, bus_b.ready_to_send}, 0);
      reset = 1'b1;
      @(negedge clock);
      check_eq("rel_ready_a", {bus_a.ready_to_load, bus_a.ready_to_send}, 3);
      check_eq("rel_ready_b", {bus_b.ready_to_load, bus_b.ready_to_send}, 3);
      check_eq("rel_data_a", bus_a.neo_data, 0);

      // GRBW strand: pixel 1 W = 0x81.
      drive_b(1, 3, 8'h81, 1'b1, 1'b0);
      drive_b(0, 0, 8'h00, 1'b0, 1'b1);
      capture_b(wb);
      eb = {};
      for (int p = 0; p < NPB; p++)
         for (int c = 0; c < NCB; c++) eb.push_back(tx(mdl_b[p][c]));
      analyse("grbw", wb, eb);

      // Single full-intensity green on pixel 0.
      drive_a(0, 0, 8'hFF, 1'b1, 1'b0);
      drive_a(0, 0, 8'h00, 1'b0, 1'b1);
      frame_a("g_ff", 1'b0);

      // Random writes, some out of range, then a write on the same cycle as send_it.
      for (int i = 0; i < 14; i++)
         drive_a($urandom_range(0, 7), $urandom_range(0, 3), 8'($urandom), 1'b1, 1'b0);
      drive_a(0, 0, 8'($urandom), 1'b1, 1'b1);
      frame_a("rand", 1'b0);

      // Resend the same store with load/send pulses mid-frame.
      drive_a(0, 0, 8'h00, 1'b0, 1'b1);
      frame_a("poke", 1'b1);

      // Abort a frame while the line is high.
      drive_a(0, 0, 8'h00, 1'b0, 1'b1);
      repeat (505) @(negedge clock);
      check_eq("abort_pre_high", bus_a.neo_data, 1);
      reset = 1'b0;
      @(negedge clock);
      check_eq("abort_data", bus_a.neo_data, 0);
      check_eq("abort_ready", {bus_a.ready_to_load, bus_a.ready_to_send}, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("abort_rel_ready", {bus_a.ready_to_load, bus_a.ready_to_send}, 3);
      clear_models();

      // Out-of-range writes only: frame of zeros.
      drive_a(7, 0, 8'hAA, 1'b1, 1'b0);
      drive_a(1, 3, 8'h55, 1'b1, 1'b0);
      drive_a(0, 0, 8'h00, 1'b0, 1'b1);
      frame_a("zeros", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
